lpc_cycle_buffer: RTL

Capture stage directly downstream of the LPC bus decoder. It samples each completed I/O cycle when the decoder's completion strobe rises and applies an optional port-address window. It packs each accepted cycle into a 32-bit record and queues records in a first-word-fall-through FIFO. The transport stage (UART/USB framer) drains the FIFO through a valid/ready handshake, all in the lpc_clock domain.

---
 rtl/lpc_pkg.sv | 30 +++
 rtl/lpc_cycle_buffer_if.sv | 13 +
 rtl/lpc_sync_fifo.sv | 63 ++++++
 rtl/lpc_cycle_buffer.sv | 100 ++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC cycle capture path: cycle-type codes,
// record field widths and the packed 32-bit record layout.
`timescale 1ns/1ps
package lpc_pkg;

  localparam int RECORD_W = 32;
  localparam int CYC_W    = 4;
  localparam int ADDR_W   = 16;
  localparam int BYTE_W   = 8;
  localparam int RSVD_W   = 2;

  localparam logic [CYC_W-1:0] CYC_IO_READ  = 4'b0000;
  localparam logic [CYC_W-1:0] CYC_IO_WRITE = 4'b0010;

  // Field order from MSB to LSB is the on-wire record layout.
  typedef struct packed {
    logic [CYC_W-1:0]  cyctype_dir;
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
    logic              loss;
    logic              timeout;
    logic [RSVD_W-1:0] rsvd;
  } lpc_record_t;

  // I/O read and I/O write share the upper type bits; the low bits carry direction.
  function automatic logic is_io_cycle(input logic [CYC_W-1:0] ct);
    return (ct[3:2] == CYC_IO_READ[3:2]) || (ct[3:2] == CYC_IO_WRITE[3:2]);
  endfunction

endpackage

// File: rtl/lpc_cycle_buffer_if.sv
// Record stream from the capture buffer to the transport framer (valid/ready).
`timescale 1ns/1ps
interface lpc_cycle_buffer_if;
  import lpc_pkg::*;

  logic [RECORD_W-1:0] out_record;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_record, output out_valid, input out_ready);
  modport slave  (input out_record, input out_valid, output out_ready);

endinterface

// File: rtl/lpc_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with full/empty/level.
`timescale 1ns/1ps
module lpc_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_en, pop_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  assign pop_en  = pop_i & ~empty_o & ~flush_i;
  assign push_en = push_i & (~full_o | pop_en) & ~flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + 1'b1;
      if (pop_en)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lpc_cycle_buffer.sv
// Captures completed LPC I/O cycles on the decoder completion edge, applies the
// optional port window, and queues 32-bit records for the transport stage.
`timescale 1ns/1ps
module lpc_cycle_buffer
  import lpc_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          FILTER_EN = 0,
  parameter logic [15:0] ADDR_LO   = 16'h0080,
  parameter logic [15:0] ADDR_HI   = 16'h0080
) (
  input  logic                   lpc_clock,
  input  logic                   lpc_reset,
  input  logic [3:0]             in_cyctype_dir,
  input  logic [31:0]            in_addr,
  input  logic [7:0]             in_data,
  input  logic                   in_clock_enable,
  input  logic                   in_sync_timeout,
  input  logic                   flush,
  lpc_cycle_buffer_if.master     out_if,
  output logic [$clog2(DEPTH):0] out_level,
  output logic [7:0]             out_overflow_count
);

  logic        prev_ce_q;
  logic        loss_q, loss_d;
  logic [7:0]  ovf_q, ovf_d;
  logic        cap_evt, win_ok, accept;
  logic        fifo_full, fifo_empty;
  logic        pop_req, push_req, drop;
  lpc_record_t rec;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^in_addr[31:16];

  // prev_ce resets high so a level already asserted out of reset is not a capture.
  assign cap_evt = in_clock_enable & ~prev_ce_q;
  assign win_ok  = (FILTER_EN == 0) ||
                   ((in_addr[15:0] >= ADDR_LO) && (in_addr[15:0] <= ADDR_HI));
  assign accept  = cap_evt & is_io_cycle(in_cyctype_dir) & win_ok & ~flush;

  assign pop_req  = out_if.out_ready & ~fifo_empty;
  assign push_req = accept & (~fifo_full | pop_req);
  assign drop     = accept & fifo_full & ~pop_req;

  always_comb begin
    rec.cyctype_dir = in_cyctype_dir;
    rec.addr        = in_addr[15:0];
    rec.data        = in_data;
    rec.loss        = loss_q;
    rec.timeout     = in_sync_timeout;
    rec.rsvd        = '0;
  end

  always_comb begin
    loss_d = loss_q;
    ovf_d  = ovf_q;
    if (flush) begin
      loss_d = 1'b0;
      ovf_d  = '0;
    end else if (push_req) begin
      loss_d = 1'b0;
    end else if (drop) begin
      loss_d = 1'b1;
      if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      prev_ce_q <= 1'b1;
      loss_q    <= 1'b0;
      ovf_q     <= '0;
    end else begin
      prev_ce_q <= in_clock_enable;
      loss_q    <= loss_d;
      ovf_q     <= ovf_d;
    end
  end

  lpc_sync_fifo #(
    .DATA_W (RECORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (lpc_clock),
    .rst_ni  (lpc_reset),
    .flush_i (flush),
    .push_i  (push_req),
    .wdata_i (rec),
    .pop_i   (pop_req),
    .rdata_o (out_if.out_record),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (out_level)
  );

  assign out_if.out_valid   = ~fifo_empty;
  assign out_overflow_count = ovf_q;

endmodule
